// File: rtl/multisum_driver_if.sv
// rtl/multisum_driver_if.sv - operand, MultiSum and result signals between the driver and its neighbours
interface multisum_driver_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ms_in0;
  logic [31:0] ms_in1;
  logic [31:0] ms_in2;
  logic [31:0] ms_in3;
  logic        ms_start;
  logic [31:0] ms_sum;
  logic        ms_done;
  logic [31:0] out_sum;
  logic        out_valid;
  logic        out_ready;
  logic        err;
  logic        busy;

  modport master (
    input  in_data, in_valid, ms_sum, ms_done, out_ready,
    output in_ready, ms_in0, ms_in1, ms_in2, ms_in3, ms_start,
    output out_sum, out_valid, err, busy
  );

  modport slave (
    output in_data, in_valid, ms_sum, ms_done, out_ready,
    input  in_ready, ms_in0, ms_in1, ms_in2, ms_in3, ms_start,
    input  out_sum, out_valid, err, busy
  );
endinterface

// File: rtl/multisum_driver.sv
// rtl/multisum_driver.sv - MultiSum initiator: gathers 4-operand groups, sequences the adder,
// accumulates GROUPS partial sums and hands the result downstream
module multisum_driver #(
  parameter int GROUPS  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  multisum_driver_if.master  bus
);
  typedef enum logic [1:0] {
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_OUT
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] slot_q [4];
  logic [31:0] slot_d [4];
  logic [7:0]  grp_q, grp_d;
  logic [31:0] acc_q, acc_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic        err_q, err_d;
  logic        done_q;
  logic        run_q;

  logic in_fire;
  logic out_fire;
  logic done_evt;
  logic tmo_hit;
  logic last_grp;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;
  // Only a rising edge counts: a level left high by the previous operation is stale.
  assign done_evt = bus.ms_done && !done_q;
  assign tmo_hit  = (tcnt_q == 16'(TIMEOUT - 1));
  assign last_grp = (({1'b0, grp_q} + 9'd1) == 9'(GROUPS));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    slot_d  = slot_q;
    grp_d   = grp_q;
    acc_d   = acc_q;
    tcnt_d  = tcnt_q;
    err_d   = err_q;
    case (state_q)
      ST_LOAD: begin
        if (in_fire) begin
          slot_d[idx_q] = bus.in_data;
          idx_d         = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = ST_START;
          end
        end
      end
      ST_START: begin
        tcnt_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        tcnt_d = tcnt_q + 16'd1;
        // A done event in the timeout cycle wins over the timeout.
        if (done_evt) begin
          acc_d   = acc_q + bus.ms_sum;
          grp_d   = grp_q + 8'd1;
          state_d = last_grp ? ST_OUT : ST_LOAD;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_fire) begin
          acc_d   = '0;
          grp_d   = '0;
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
      for (int k = 0; k < 4; k++) begin
        slot_q[k] <= '0;
      end
      grp_q   <= '0;
      acc_q   <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      slot_q  <= slot_d;
      grp_q   <= grp_d;
      acc_q   <= acc_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
      done_q  <= bus.ms_done;
      run_q   <= 1'b1;
    end
  end

  // run_q keeps in_ready low while reset is asserted even though the state is LOAD.
  assign bus.in_ready  = run_q && (state_q == ST_LOAD);
  assign bus.ms_in0    = slot_q[0];
  assign bus.ms_in1    = slot_q[1];
  assign bus.ms_in2    = slot_q[2];
  assign bus.ms_in3    = slot_q[3];
  assign bus.ms_start  = (state_q == ST_START);
  assign bus.out_valid = (state_q == ST_OUT);
  assign bus.out_sum   = acc_q;
  assign bus.err       = err_q;
  assign bus.busy      = !((state_q == ST_LOAD) && (idx_q == 2'd0) && (grp_q == 8'd0));
endmodule

// File: doc/multisum_driver.md
Name: multisum_driver

Overview:
- Initiator for a MultiSum adder. Collects a serial stream of 32-bit operands into groups of four and presents each group on ms_in0..ms_in3.
- Issues a one-cycle start pulse, waits for a rising edge on done, and captures the partial sum.
- Accumulates GROUPS partial sums into one neuron pre-activation value, then hands it downstream over a valid/ready handshake.

Parameters:
- GROUPS, 2, number of 4-operand groups summed per output result (1..255).
- TIMEOUT, 64, maximum clk cycles in WAIT before the error is flagged (1..65535).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  32  operand word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  driver accepts in_data this cycle.
- ms_in0..ms_in3  output  32 each  operands to MultiSum.
- ms_start  output  1  start pulse to MultiSum.
- ms_sum  input  32  MultiSum result.
- ms_done  input  1  MultiSum done (edge-significant).
- out_sum  output  32  accumulated result.
- out_valid  output  1  out_sum valid.
- out_ready  input  1  downstream accepts out_sum.
- err  output  1  sticky timeout flag.
- busy  output  1  high in any state other than LOAD with slot 0 empty and group count 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to LOAD; all outputs, slot index, group count, accumulator, done_q and timeout counter go to 0.
  - Reset mid-operation discards partial groups and the accumulator with no output.
- Handshakes:
  - An input beat transfers when in_valid&&in_ready on a rising clk edge.
  - An output beat transfers when out_valid&&out_ready.
- LOAD:
  - in_ready=1.
  - Each accepted word is written to slot[idx]; idx goes 0→1→2→3.
  - On acceptance of slot 3, go to START with idx=0.
  - ms_in0..3 are driven directly from the slot registers.
- START:
  - ms_start=1 for exactly one cycle; in_ready=0.
  - Next state is WAIT. The timeout counter clears.
- WAIT:
  - in_ready=0; ms_in0..3 held stable.
  - done_q is ms_done registered every cycle. A done event is ms_done=1 && done_q=0.
  - A level still high from the previous operation is not an event.
  - On a done event:
    - acc <= acc + ms_sum, modulo 2^32, wrap with no saturation.
    - Group count increments.
    - If group count reaches GROUPS, go to OUT; otherwise go to LOAD.
  - Timeout: if the counter reaches TIMEOUT with no event, set err=1 (cleared only by reset) and go to OUT with the acc value as is.
- OUT:
  - out_valid=1 with out_sum=acc, held stable until out_ready.
  - On transfer: acc, group count and out_valid clear next cycle; go to LOAD.
  - out_valid may not drop without a transfer.
- Latency:
  - In WAIT, the first cycle that shows a done event causes out_valid=1 on the next cycle (final group).
  - With in_valid held high, the minimum time from first operand to ms_start is 4 cycles.
- Simultaneous events:
  - A done event and the timeout in the same cycle: the done event wins, err is not set.
  - In OUT, in_valid is ignored (in_ready=0).
- ms_done pulses outside WAIT are ignored, but done_q still tracks them.

Test Plan:
- GROUPS=1. Words 1,1,1,1; bench MultiSum model raises done 3 cycles after start. Expect:
  - ms_start high exactly 1 cycle.
  - ms_in0..3=1.
  - out_sum=4 and out_valid one cycle after the done edge.
  - err=0.
- GROUPS=2. Words 1..8 with in_valid gaps of 2 cycles. Expect:
  - Two start pulses.
  - Partial sums 10 and 26.
  - out_sum=36.
  - busy high from first beat until the out transfer.
- Wrap. GROUPS=2, partial sums 0xFFFFFFFF and 0x00000002. Expect out_sum=0x00000001.
- Backpressure. out_ready=0 for 10 cycles after out_valid. Expect:
  - out_sum stable.
  - in_ready=0 throughout.
  - Transfer on the first out_ready=1.
  - The next group loads normally.
- Timeout. TIMEOUT=8, model never raises done. Expect err=1 and out_valid with out_sum=0 at 8 cycles after START exits. Also drive done at exactly the timeout cycle: out_sum is captured and err=0.
- Stale done / reset. Hold ms_done high through the second START; the driver waits for a fresh rising edge. Assert reset=0 mid-WAIT. Expect:
  - All outputs 0 immediately (asynchronous).
  - After release, the state is LOAD and a new 4-word group computes correctly.
